alu_arbiter: RTL

- Shares the single 8-bit ALU between two requesters, such as the instruction-execute path and a debug/DMA port.
- Each requester sends a valid/ready request carrying opcode and two operands.
- The block arbitrates round-robin, drives the ALU from registered operands, captures the result, and returns it on one shared response channel tagged with the requester id.
- It also flags divide-by-zero and the unused opcode.

---
 rtl/alu_arbiter.sv | 108 ++++++++++
 1 files changed

// File: rtl/alu_arbiter.sv
// Round-robin front end that lets two requesters share one external ALU.
// Requests are granted in IDLE, executed for one cycle, and returned on a single tagged response channel.
module alu_arbiter #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req0_valid,
   output logic             req0_ready,
   input  logic [2:0]       req0_op,
   input  logic [WIDTH-1:0] req0_a,
   input  logic [WIDTH-1:0] req0_b,
   input  logic             req1_valid,
   output logic             req1_ready,
   input  logic [2:0]       req1_op,
   input  logic [WIDTH-1:0] req1_a,
   input  logic [WIDTH-1:0] req1_b,
   output logic [WIDTH-1:0] alu_operand1,
   output logic [WIDTH-1:0] alu_operand2,
   output logic [2:0]       alu_operation,
   input  logic [WIDTH-1:0] alu_result,
   input  logic             alu_carry,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic             rsp_id,
   output logic [WIDTH-1:0] rsp_result,
   output logic             rsp_carry,
   output logic             rsp_err
);

   localparam logic [2:0] OP_ADD = 3'b000;
   localparam logic [2:0] OP_DIV = 3'b011;
   localparam logic [2:0] OP_ILL = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      RESP = 2'd2
   } state_t;

   // Handshake: a request transfers in a cycle where reqN_valid and reqN_ready
   // are both high; a response transfers where rsp_valid and rsp_ready are both high.
   state_t state;
   logic   last_grant;
   logic   any_valid;
   logic   grant_id;

   always_comb begin
      any_valid = req0_valid | req1_valid;
      grant_id  = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
   end

   // Ready is gated by rst so both stay low while reset is held.
   assign req0_ready = !rst && (state == IDLE) && any_valid && !grant_id;
   assign req1_ready = !rst && (state == IDLE) && any_valid &&  grant_id;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state         <= IDLE;
         last_grant    <= 1'b1;
         alu_operand1  <= '0;
         alu_operand2  <= '0;
         alu_operation <= 3'b000;
         rsp_valid     <= 1'b0;
         rsp_id        <= 1'b0;
         rsp_result    <= '0;
         rsp_carry     <= 1'b0;
         rsp_err       <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (any_valid) begin
                  alu_operation <= grant_id ? req1_op : req0_op;
                  alu_operand1  <= grant_id ? req1_a  : req0_a;
                  alu_operand2  <= grant_id ? req1_b  : req0_b;
                  rsp_id        <= grant_id;
                  last_grant    <= grant_id;
                  state         <= EXEC;
               end
            end
            EXEC: begin
               rsp_result <= alu_result;
               rsp_carry  <= (alu_operation == OP_ADD) ? alu_carry : 1'b0;
               rsp_err    <= 1'b0;
               // The ALU output is meaningless for these cases, so report zero plus an error.
               if (((alu_operation == OP_DIV) && (alu_operand2 == '0)) ||
                   (alu_operation == OP_ILL)) begin
                  rsp_result <= '0;
                  rsp_err    <= 1'b1;
               end
               rsp_valid <= 1'b1;
               state     <= RESP;
            end
            RESP: begin
               if (rsp_ready) begin
                  rsp_valid  <= 1'b0;
                  rsp_result <= '0;
                  rsp_carry  <= 1'b0;
                  rsp_err    <= 1'b0;
                  state      <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
